// File: rtl/control_pkg.sv
// Shared constants for the left/right control path: source codes, arbiter
// state encoding and the default accelerometer direction codes.
package control_pkg;

  localparam logic [1:0] SRC_BTN   = 2'd0;
  localparam logic [1:0] SRC_MOUSE = 2'd1;
  localparam logic [1:0] SRC_ACCEL = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arbState_t;

  localparam logic [7:0] ACCEL_IZQ_DEF = 8'd41;
  localparam logic [7:0] ACCEL_DER_DEF = 8'd23;

endpackage

// File: rtl/move_rate_gen.sv
// Turns a held left/right intent into registered, rate-limited move pulses:
// one pulse on a new direction, then one every MOVE_PERIOD cycles while held.
module move_rate_gen #(
  parameter int MOVE_PERIOD = 2_500_000
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic der,
  input  logic izq,
  output logic moveDer,
  output logic moveIzq
);

  localparam int CW = $clog2(MOVE_PERIOD);
  localparam logic [CW-1:0] RATE_LAST = CW'(MOVE_PERIOD - 1);

  logic [CW-1:0] rateCnt;
  logic          prevDer;
  logic          prevIzq;

  always_ff @(posedge clk) begin
    if (!rstN || clear) begin
      rateCnt <= '0;
      prevDer <= 1'b0;
      prevIzq <= 1'b0;
      moveDer <= 1'b0;
      moveIzq <= 1'b0;
    end else begin
      prevDer <= der;
      prevIzq <= izq;
      moveDer <= 1'b0;
      moveIzq <= 1'b0;
      if (!(der || izq)) begin
        rateCnt <= '0;
      end else if ((der != prevDer) || (izq != prevIzq)) begin
        // Rising edge or direction reversal: immediate pulse, restart pacing.
        rateCnt <= '0;
        moveDer <= der;
        moveIzq <= izq;
      end else if (rateCnt == RATE_LAST) begin
        rateCnt <= '0;
        moveDer <= der;
        moveIzq <= izq;
      end else begin
        rateCnt <= rateCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/control_source_arbiter.sv
// Decides which source (buttons, mouse, accelerometer) owns the left/right
// control and converts the owner's held direction into move pulses.
module control_source_arbiter
  import control_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50_000_000,
  parameter int         MOVE_PERIOD = 2_500_000,
  parameter logic [7:0] ACCEL_IZQ   = ACCEL_IZQ_DEF,
  parameter logic [7:0] ACCEL_DER   = ACCEL_DER_DEF
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iauto_en,
  input  logic [1:0] imanual_sel,
  input  logic       ibtn_der,
  input  logic       ibtn_izq,
  input  logic [5:0] imouse,
  input  logic [7:0] iaccel,
  output logic [1:0] osel,
  output logic       ogrant_valid,
  output logic       omove_der,
  output logic       omove_izq
);

  localparam int IW = $clog2(TIMEOUT_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  logic btnDer, btnIzq, mouseDer, mouseIzq, accelDer, accelIzq;
  logic btnAct, mouseAct, accelAct;
  logic ownerDer, ownerIzq, ownerActive;

  arbState_t     state, stateNext;
  logic [1:0]    selNext;
  logic          grantNext;
  logic [IW-1:0] idleCnt, idleCntNext;
  logic          moveClear;

  assign btnDer   = ibtn_der;
  assign btnIzq   = ibtn_izq & ~ibtn_der;
  assign mouseDer = imouse[5];
  assign mouseIzq = (imouse[0] | imouse[1] | imouse[2]) & ~imouse[5];
  assign accelIzq = (iaccel == ACCEL_IZQ);
  assign accelDer = (iaccel == ACCEL_DER);

  assign btnAct   = btnDer | btnIzq;
  assign mouseAct = mouseDer | mouseIzq;
  assign accelAct = accelDer | accelIzq;

  // Intent of whichever source the registered select currently names.
  always_comb begin
    ownerDer = accelDer;
    ownerIzq = accelIzq;
    case (osel)
      SRC_BTN:   begin ownerDer = btnDer;   ownerIzq = btnIzq;   end
      SRC_MOUSE: begin ownerDer = mouseDer; ownerIzq = mouseIzq; end
      default:   begin ownerDer = accelDer; ownerIzq = accelIzq; end
    endcase
  end

  assign ownerActive = ownerDer | ownerIzq;

  always_comb begin
    stateNext   = state;
    selNext     = osel;
    grantNext   = ogrant_valid;
    idleCntNext = idleCnt;
    if (!iauto_en) begin
      stateNext   = ST_IDLE;
      idleCntNext = '0;
      grantNext   = 1'b1;
      selNext     = (imanual_sel == 2'd3) ? SRC_ACCEL : imanual_sel;
    end else begin
      case (state)
        ST_IDLE: begin
          idleCntNext = '0;
          grantNext   = 1'b0;
          if (btnAct) begin
            stateNext = ST_OWNED; selNext = SRC_BTN;   grantNext = 1'b1;
          end else if (mouseAct) begin
            stateNext = ST_OWNED; selNext = SRC_MOUSE; grantNext = 1'b1;
          end else if (accelAct) begin
            stateNext = ST_OWNED; selNext = SRC_ACCEL; grantNext = 1'b1;
          end
        end
        ST_OWNED: begin
          if (ownerActive) begin
            idleCntNext = '0;
          end else if (idleCnt == IDLE_LAST) begin
            stateNext   = ST_IDLE;
            grantNext   = 1'b0;
            idleCntNext = '0;
          end else begin
            idleCntNext = idleCnt + IW'(1);
          end
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  // A fresh grant or a different owner restarts move pacing, so an owner
  // already holding a direction pulses right after its grant is visible.
  assign moveClear = grantNext & (~ogrant_valid | (selNext != osel));

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state        <= ST_IDLE;
      osel         <= SRC_BTN;
      ogrant_valid <= 1'b0;
      idleCnt      <= '0;
    end else begin
      state        <= stateNext;
      osel         <= selNext;
      ogrant_valid <= grantNext;
      idleCnt      <= idleCntNext;
    end
  end

  move_rate_gen #(
    .MOVE_PERIOD(MOVE_PERIOD)
  ) uMoveRateGen (
    .clk     (iclk),
    .rstN    (irst_n),
    .clear   (moveClear),
    .der     (ogrant_valid & ownerDer),
    .izq     (ogrant_valid & ownerIzq),
    .moveDer (omove_der),
    .moveIzq (omove_izq)
  );

endmodule

// File: tb/tb_control_source_arbiter.sv
// Directed bench for control_source_arbiter with TIMEOUT_CYC = 8, MOVE_PERIOD = 4.
// Expected words are {osel[1:0], ogrant_valid, omove_der, omove_izq}.
module tb_control_source_arbiter;

  localparam int TIMEOUT_CYC = 8;
  localparam int MOVE_PERIOD = 4;

  logic       iclk = 1'b0;
  logic       irst_n;
  logic       iauto_en;
  logic [1:0] imanual_sel;
  logic       ibtn_der;
  logic       ibtn_izq;
  logic [5:0] imouse;
  logic [7:0] iaccel;
  logic [1:0] osel;
  logic       ogrant_valid;
  logic       omove_der;
  logic       omove_izq;

  int vectors     = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];

  control_source_arbiter #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MOVE_PERIOD(MOVE_PERIOD),
    .ACCEL_IZQ  (8'd41),
    .ACCEL_DER  (8'd23)
  ) dut (
    .iclk         (iclk),
    .irst_n       (irst_n),
    .iauto_en     (iauto_en),
    .imanual_sel  (imanual_sel),
    .ibtn_der     (ibtn_der),
    .ibtn_izq     (ibtn_izq),
    .imouse       (imouse),
    .iaccel       (iaccel),
    .osel         (osel),
    .ogrant_valid (ogrant_valid),
    .omove_der    (omove_der),
    .omove_izq    (omove_izq)
  );

  // clock / reset
  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic idle_inputs();
    iauto_en    = 1'b1;
    imanual_sel = 2'd0;
    ibtn_der    = 1'b0;
    ibtn_izq    = 1'b0;
    imouse      = 6'd0;
    iaccel      = 8'd0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    irst_n = 1'b0;
    tick();
    tick();
    irst_n = 1'b1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {osel, ogrant_valid, omove_der, omove_izq};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed sel/grant/der/izq=%b required %b", tag, observed, expected);
    end
  endtask

  initial begin
    // 1. reset with every source active
    idle_inputs();
    ibtn_der = 1'b1;
    imouse   = 6'b100000;
    iaccel   = 8'd41;
    irst_n   = 1'b0;
    tick();
    tick();
    check("rst_hold", 5'b00_0_0_0);
    irst_n = 1'b1;
    #2;
    check("rst_release_pre_edge", 5'b00_0_0_0);
    tick();
    check("rst_first_grant", 5'b00_1_0_0);
    tick();
    check("rst_first_pulse", 5'b00_1_1_0);

    // 2. simultaneous buttons-left and mouse-right: buttons win
    reset_dut();
    ibtn_izq = 1'b1;
    imouse   = 6'b100000;
    tick();
    check("prio_grant", 5'b00_1_0_0);
    tick();
    check("prio_izq_pulse", 5'b00_1_0_1);
    ibtn_izq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("prio_mouse_ignored", 5'b00_1_0_0);
    end

    // 3. repeat rate: grant edge, then 13 intent edges, then release
    reset_dut();
    for (int i = 0; i < 17; i++)
      exp_q.push_back(5'b00_1_0_0);
    exp_q[1]  = 5'b00_1_1_0;
    exp_q[5]  = 5'b00_1_1_0;
    exp_q[9]  = 5'b00_1_1_0;
    exp_q[13] = 5'b00_1_1_0;
    for (int i = 0; i < 17; i++) begin
      ibtn_der = (i < 14);
      tick();
      check("rate_seq", exp_q.pop_front());
    end

    // 4. mouse times out, accelerometer takes over
    reset_dut();
    imouse = 6'b000001;
    tick();
    check("to_mouse_grant", 5'b01_1_0_0);
    tick();
    check("to_mouse_pulse", 5'b01_1_0_1);
    imouse = 6'd0;
    iaccel = 8'd41;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) check("to_still_owned", 5'b01_1_0_0);
      else       check("to_released", 5'b01_0_0_0);
    end
    tick();
    check("to_accel_grant", 5'b10_1_0_0);
    tick();
    check("to_accel_pulse", 5'b10_1_0_1);

    // 5. manual override, owner change, then back to auto
    reset_dut();
    iauto_en    = 1'b0;
    imanual_sel = 2'd3;
    iaccel      = 8'd23;
    ibtn_izq    = 1'b1;
    tick();
    check("man_grant", 5'b10_1_0_0);
    tick();
    check("man_der_pulse", 5'b10_1_1_0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("man_between", 5'b10_1_0_0);
    end
    tick();
    check("man_repeat", 5'b10_1_1_0);
    imanual_sel = 2'd1;
    imouse      = 6'b100000;
    tick();
    check("man_owner_change", 5'b01_1_0_0);
    tick();
    check("man_new_owner_pulse", 5'b01_1_1_0);
    iauto_en = 1'b1;
    tick();
    check("auto_reentry_grant", 5'b00_1_0_0);
    tick();
    check("auto_reentry_pulse", 5'b00_1_0_1);

    // 6. reset in the cycle before a repeat pulse is due
    reset_dut();
    ibtn_der = 1'b1;
    tick();
    check("mid_grant", 5'b00_1_0_0);
    tick();
    check("mid_first_pulse", 5'b00_1_1_0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_hold", 5'b00_1_0_0);
    end
    irst_n = 1'b0;
    tick();
    check("mid_reset_kills_pulse", 5'b00_0_0_0);
    irst_n = 1'b1;
    tick();
    check("mid_regrant", 5'b00_1_0_0);
    tick();
    check("mid_restart_pulse", 5'b00_1_1_0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_source_arbiter.md
Name: control_source_arbiter

Overview:
Owns the left/right game control. It decides which input source (board buttons, mouse, accelerometer) holds control at any time. In auto mode, the first source to become active takes ownership and keeps it until it has been idle for a timeout. The block then turns the owner's held direction into registered, rate-limited move pulses for the paddle/player logic, and it drives the 2-bit source-select code used elsewhere in the control path.

Parameters:
TIMEOUT_CYC, 50_000_000, number of consecutive owner-idle cycles before ownership is released (1 s at 50 MHz); minimum 2.
MOVE_PERIOD, 2_500_000, cycles between repeated move pulses while a direction is held; minimum 2.
ACCEL_IZQ, 8'd41, accelerometer code meaning "tilt left".
ACCEL_DER, 8'd23, accelerometer code meaning "tilt right"; must differ from ACCEL_IZQ.

Ports:
iclk  in  1  system clock; the only clock.
irst_n  in  1  synchronous reset, active-low.
iauto_en  in  1  1 = automatic ownership arbitration; 0 = manual source selection.
imanual_sel  in  2  manual source: 0 = buttons, 1 = mouse, 2 or 3 = accelerometer.
ibtn_der  in  1  right button, already debounced.
ibtn_izq  in  1  left button, already debounced.
imouse  in  6  mouse status, bits [0:5].
iaccel  in  8  accelerometer direction code.
osel  out  2  current owner code (0 buttons, 1 mouse, 2 accelerometer); registered.
ogrant_valid  out  1  1 when a source owns control; registered.
omove_der  out  1  one-cycle move-right pulse; registered.
omove_izq  out  1  one-cycle move-left pulse; registered.

Behaviour:
- Reset: one clock, synchronous, active-low (irst_n = 0 sampled on the iclk rising edge). After reset:
  - all outputs are 0;
  - state is IDLE;
  - the idle counter and the rate counter are 0;
  - the previous-intent register is 0.
- Per-source intent decode (combinational):
  - Buttons: der = ibtn_der; izq = ibtn_izq & ~ibtn_der.
  - Mouse: der = imouse[5]; izq = (imouse[0] | imouse[1] | imouse[2]) & ~imouse[5].
  - Accelerometer: izq = (iaccel == ACCEL_IZQ); der = (iaccel == ACCEL_DER). Any other code means no intent.
  - A source is "active" when der | izq. der and izq are never both 1.
- Manual mode (iauto_en = 0):
  - owner = imanual_sel, with 3 mapped to 2.
  - ogrant_valid = 1 and osel = owner, both registered (1-cycle latency).
  - The FSM is held in IDLE and the idle counter is held at 0.
- Auto mode FSM, states IDLE and OWNED:
  - IDLE:
    - If any source is active, go to OWNED. Priority when several are active: buttons > mouse > accelerometer.
    - In that cycle, osel is loaded and ogrant_valid is set to 1; both are visible the next cycle.
    - With no source active, stay in IDLE with ogrant_valid = 0 and osel unchanged.
  - OWNED:
    - Owner active: clear the idle counter. Owner inactive: increment it.
    - When the counter equals TIMEOUT_CYC-1 and the owner is still inactive, go to IDLE: ogrant_valid goes to 0 and the counter clears.
    - Activity on non-owner sources is ignored.
  - Switching iauto_en 1→0: the FSM goes to IDLE and counters clear, then manual rules apply the next cycle.
  - Switching iauto_en 0→1: the FSM starts from IDLE.
- Move generation (uses the registered owner and the owner's decoded intent; only while ogrant_valid = 1):
  - On the first cycle of a new direction intent, the matching omove pulse is asserted in the next cycle and the rate counter restarts at 0. "New" means a rising edge against the previous-intent register, or a direction change.
  - While the same direction is held, another pulse fires each time the rate counter reaches MOVE_PERIOD-1; the counter then wraps to 0.
  - When intent is released, the rate counter clears and no pulse is produced.
  - An owner change (in either mode) clears the previous-intent register and the rate counter. A new owner already holding a direction therefore gets a pulse one cycle after the grant becomes visible.
  - omove_der and omove_izq are never 1 in the same cycle.
  - No pulses are produced while ogrant_valid = 0.
- Counter widths: $clog2 of the respective parameter. Counters saturate-free by construction, since they are compared against parameter-1 and cleared.

Decomposition:
- Shared package `control_pkg` holds:
  - source code constants SRC_BTN = 2'd0, SRC_MOUSE = 2'd1, SRC_ACCEL = 2'd2;
  - state encodings ST_IDLE and ST_OWNED;
  - the default accelerometer codes.
- One sub-module, `move_rate_gen`:
  - inputs: clock, reset, clear, der intent, izq intent;
  - outputs: registered pulses;
  - parameterised by MOVE_PERIOD;
  - owns the rate counter and the previous-intent register.
- The arbiter FSM and the intent decode stay in the top module.

Test Plan:
All scenarios use TIMEOUT_CYC = 8 and MOVE_PERIOD = 4.
1. Reset: irst_n = 0 for 2 cycles with all sources active → osel = 0, ogrant_valid = 0, no move pulses; outputs change only after irst_n = 1.
2. Auto grant and priority: ibtn_izq = 1 and imouse[5] = 1 asserted in the same cycle → next cycle osel = 0, ogrant_valid = 1, omove_izq pulses once; mouse never produces a pulse.
3. Repeat rate: buttons own control and ibtn_der is held for 13 cycles → omove_der pulses at intent+1, then every 4 cycles (4 pulses total); no pulses once released.
4. Timeout and handover: mouse owns control, then goes idle with the accelerometer active (iaccel = 41) → ogrant_valid drops after exactly 8 idle cycles. The next cycle osel = 2 and omove_izq pulses.
5. Manual override: iauto_en = 0, imanual_sel = 3, iaccel = 23 → osel = 2, ogrant_valid = 1, omove_der pulses; the button inputs are ignored.
6. Reset mid-operation: irst_n = 0 mid-hold, in the cycle before a repeat pulse is due → that pulse is not emitted, all outputs go to 0, and after release arbitration restarts from IDLE.
